// File: rtl/dac_playout_buffer_pkg.sv
// Shared constants, state encoding and helpers for the DAC playout buffer.
package dac_playout_pkg;

  localparam int          STAT_W   = 16;
  localparam logic [13:0] MIDSCALE = 14'h2000;

  typedef enum logic {
    ST_PRIME = 1'b0,
    ST_PLAY  = 1'b1
  } state_t;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
    return (value == '1) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/dac_playout_buffer_if.sv
// Sample-path bundle between the host-link stage and the DAC driver.
// Stats counters exist only when DAC_PLAYOUT_STATS_EN is defined.
interface dac_playout_buffer_if
  import dac_playout_pkg::*;
#(
  parameter int DATA_W = 14,
  parameter int DEPTH  = 64
);
  localparam int FILL_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] dac_data_i;
  logic              dac_data_rdy_i;
  logic [DATA_W-1:0] sample_data_o;
  logic              sample_strobe_o;
  logic              playing_o;
  logic              underrun_o;
  logic              overflow_o;
  logic [FILL_W-1:0] fill_level_o;
`ifdef DAC_PLAYOUT_STATS_EN
  logic [STAT_W-1:0] underrun_count_o;
  logic [STAT_W-1:0] overflow_count_o;
`endif

  modport master (
    output dac_data_i,
    output dac_data_rdy_i,
    input  sample_data_o,
    input  sample_strobe_o,
    input  playing_o,
    input  underrun_o,
    input  overflow_o,
`ifdef DAC_PLAYOUT_STATS_EN
    input  underrun_count_o,
    input  overflow_count_o,
`endif
    input  fill_level_o
  );

  modport slave (
    input  dac_data_i,
    input  dac_data_rdy_i,
    output sample_data_o,
    output sample_strobe_o,
    output playing_o,
    output underrun_o,
    output overflow_o,
`ifdef DAC_PLAYOUT_STATS_EN
    output underrun_count_o,
    output overflow_count_o,
`endif
    output fill_level_o
  );

endinterface

// File: rtl/dac_playout_buffer_sync_fifo.sv
// Count-based synchronous FIFO with registered pop data that holds between pops.
module sync_fifo #(
  parameter int                DATA_W  = 14,
  parameter int                DEPTH   = 64,
  parameter logic [DATA_W-1:0] RD_INIT = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              do_push;
  logic              do_pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_pop   = pop && !empty;
  // A push into a full FIFO is accepted only when a pop frees the slot this cycle.
  assign do_push  = push && (!full || do_pop);
  assign count    = count_q;
  assign pop_data = rd_data_q;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      rd_data_q <= RD_INIT;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_data_q <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/dac_playout_buffer.sv
// Jitter buffer re-timing bursty host samples onto a fixed-rate DAC strobe.
// Define DAC_PLAYOUT_STATS_EN to add saturating underrun/overflow counters.
module dac_playout_buffer
  import dac_playout_pkg::*;
#(
  parameter int DATA_W      = 14,
  parameter int DEPTH       = 64,
  parameter int PRIME_LEVEL = 32,
  parameter int SAMPLE_DIV  = 375
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  dac_playout_buffer_if.slave  bus
);
  // state    | meaning
  // ST_PRIME | filling; strobes re-present the held sample, no pops
  // ST_PLAY  | one pop per tick; empty at a tick is an underrun

  localparam int                FILL_W = $clog2(DEPTH) + 1;
  localparam int                DIV_W  = $clog2(SAMPLE_DIV);
  localparam logic [DATA_W-1:0] MID    = DATA_W'(MIDSCALE);

  logic [DIV_W-1:0]  div_q;
  logic              tick;
  state_t            state_q;
  state_t            state_d;
  logic              pop;
  logic              underrun_d;
  logic              overflow_d;
  logic              fifo_push;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FILL_W-1:0] fifo_count;
  logic [DATA_W-1:0] fifo_data;
  logic              strobe_q;
  logic              underrun_q;
  logic              overflow_q;

  assign tick = (div_q == DIV_W'(SAMPLE_DIV - 1));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_PRIME;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    underrun_d = 1'b0;
    case (state_q)
      ST_PRIME: begin
        if (fifo_count >= FILL_W'(PRIME_LEVEL)) begin
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (tick) begin
          if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            underrun_d = 1'b1;
            state_d    = ST_PRIME;
          end
        end
      end
      default: state_d = ST_PRIME;
    endcase
  end

  // Full only blocks a push when no pop is freeing a slot in the same cycle.
  assign fifo_push  = bus.dac_data_rdy_i && (!fifo_full || pop);
  assign overflow_d = bus.dac_data_rdy_i && fifo_full && !pop;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .RD_INIT(MID)
  ) u_fifo (
    .clk      (clk_i),
    .rst      (reset_i),
    .push     (fifo_push),
    .push_data(bus.dac_data_i),
    .pop      (pop),
    .pop_data (fifo_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      strobe_q   <= tick;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.sample_data_o   = fifo_data;
  assign bus.sample_strobe_o = strobe_q;
  assign bus.playing_o       = (state_q == ST_PLAY);
  assign bus.underrun_o      = underrun_q;
  assign bus.overflow_o      = overflow_q;
  assign bus.fill_level_o    = fifo_count;

`ifdef DAC_PLAYOUT_STATS_EN
  logic [STAT_W-1:0] underrun_cnt_q;
  logic [STAT_W-1:0] overflow_cnt_q;

  // Counters advance on the same edge that raises the matching pulse.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      underrun_cnt_q <= '0;
      overflow_cnt_q <= '0;
    end else begin
      if (underrun_d) begin
        underrun_cnt_q <= sat_inc(underrun_cnt_q);
      end
      if (overflow_d) begin
        overflow_cnt_q <= sat_inc(overflow_cnt_q);
      end
    end
  end

  assign bus.underrun_count_o = underrun_cnt_q;
  assign bus.overflow_count_o = overflow_cnt_q;
`endif

endmodule

// File: tb/tb_dac_playout_buffer.sv
// Directed bench for dac_playout_buffer: priming, playout order, underrun, overflow, reset.
module tb_dac_playout_buffer;
  import dac_playout_pkg::*;

  localparam int DATA_W      = 14;
  localparam int DEPTH       = 64;
  localparam int PRIME_LEVEL = 32;
  localparam int SAMPLE_DIV  = 375;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_chk      = 0;
  int n_err      = 0;
  int cyc        = 0;
  int ovf_seen   = 0;
  int ovf_base   = 0;
  int prev_strb  = 0;
  int tick_base  = 0;
  logic ok;

  dac_playout_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  dac_playout_buffer #(
    .DATA_W     (DATA_W),
    .DEPTH      (DEPTH),
    .PRIME_LEVEL(PRIME_LEVEL),
    .SAMPLE_DIV (SAMPLE_DIV)
  ) dut (
    .clk_i  (clk),
    .reset_i(rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at cyc %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.overflow_o === 1'b1) ovf_seen++;
  endtask

  task automatic wait_strobe(input int max_cyc, output logic found);
    found = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      step();
      if (bus.sample_strobe_o === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) chk("strobe_timeout", {31'd0, found}, 32'd1);
  endtask

  task automatic push_n(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      bus.dac_data_i     = DATA_W'(base + i);
      bus.dac_data_rdy_i = 1'b1;
      step();
    end
    bus.dac_data_rdy_i = 1'b0;
  endtask

  initial begin
    bus.dac_data_i     = '0;
    bus.dac_data_rdy_i = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    cyc = 0;

    // reset values
    chk("rst_data", bus.sample_data_o, 32'h2000);
    chk("rst_strobe", bus.sample_strobe_o, 0);
    chk("rst_playing", bus.playing_o, 0);
    chk("rst_underrun", bus.underrun_o, 0);
    chk("rst_overflow", bus.overflow_o, 0);
    chk("rst_fill", bus.fill_level_o, 0);
`ifdef DAC_PLAYOUT_STATS_EN
    chk("rst_urun_cnt", bus.underrun_count_o, 0);
    chk("rst_ovf_cnt", bus.overflow_count_o, 0);
`endif

    // idle: first strobe at cycle 375 with midscale
    wait_strobe(400, ok);
    chk("first_strobe_cyc", cyc, 375);
    chk("idle_data", bus.sample_data_o, 32'h2000);
    chk("idle_playing", bus.playing_o, 0);
    chk("idle_fill", bus.fill_level_o, 0);

    // prime with 1..32 and play them back in order
    push_n(32, 1);
    chk("prime_fill", bus.fill_level_o, 32);
    chk("prime_not_yet", bus.playing_o, 0);
    step();
    chk("playing_rise", bus.playing_o, 1);
    prev_strb = 0;
    for (int i = 1; i <= 32; i++) begin
      wait_strobe(400, ok);
      chk("play_data", bus.sample_data_o, 32'(i));
      chk("play_fill", bus.fill_level_o, 32'(32 - i));
      chk("play_no_urun", bus.underrun_o, 0);
      if (i > 1) chk("strobe_period", cyc - prev_strb, 375);
      prev_strb = cyc;
    end

    // 33rd strobe: underrun, hold last sample
    wait_strobe(400, ok);
    chk("urun_data", bus.sample_data_o, 32'h20);
    chk("urun_pulse", bus.underrun_o, 1);
    chk("urun_playing", bus.playing_o, 0);
    chk("urun_period", cyc - prev_strb, 375);
`ifdef DAC_PLAYOUT_STATS_EN
    chk("urun_cnt_1", bus.underrun_count_o, 1);
`endif
    step();
    chk("urun_one_cycle", bus.underrun_o, 0);

    // 70 pushes into empty PRIME buffer: 6 drops
    ovf_base = ovf_seen;
    push_n(70, 1);
    step();
    chk("ovf_pulses", ovf_seen - ovf_base, 6);
    chk("ovf_fill", bus.fill_level_o, 64);
    chk("ovf_playing", bus.playing_o, 1);
`ifdef DAC_PLAYOUT_STATS_EN
    chk("ovf_cnt_6", bus.overflow_count_o, 6);
`endif
    for (int i = 1; i <= 64; i++) begin
      wait_strobe(400, ok);
      chk("ovf_play_data", bus.sample_data_o, 32'(i));
      chk("ovf_play_urun", bus.underrun_o, 0);
    end
    wait_strobe(400, ok);
    chk("ovf_urun_data", bus.sample_data_o, 32'h40);
    chk("ovf_urun_pulse", bus.underrun_o, 1);
`ifdef DAC_PLAYOUT_STATS_EN
    chk("urun_cnt_2", bus.underrun_count_o, 2);
`endif

    // full in PLAY, push exactly on a tick: pop and push both succeed
    tick_base = cyc;
    push_n(64, 'h100);
    chk("full_fill", bus.fill_level_o, 64);
    chk("full_playing", bus.playing_o, 1);
    while (cyc < tick_base + SAMPLE_DIV - 1) step();
    bus.dac_data_i     = DATA_W'('h3FFF);
    bus.dac_data_rdy_i = 1'b1;
    step();
    bus.dac_data_rdy_i = 1'b0;
    chk("tick_push_strobe", bus.sample_strobe_o, 1);
    chk("tick_push_data", bus.sample_data_o, 32'h100);
    chk("tick_push_no_ovf", bus.overflow_o, 0);
    chk("tick_push_fill", bus.fill_level_o, 64);

    // full without a pop: dropped
    bus.dac_data_i     = DATA_W'('h1234);
    bus.dac_data_rdy_i = 1'b1;
    step();
    bus.dac_data_rdy_i = 1'b0;
    chk("full_drop_ovf", bus.overflow_o, 1);
    chk("full_drop_fill", bus.fill_level_o, 64);
`ifdef DAC_PLAYOUT_STATS_EN
    chk("ovf_cnt_7", bus.overflow_count_o, 7);
`endif

    // reset mid-playout
    rst = 1'b1;
    step();
    rst = 1'b0;
    cyc = 0;
    chk("mid_rst_fill", bus.fill_level_o, 0);
    chk("mid_rst_data", bus.sample_data_o, 32'h2000);
    chk("mid_rst_playing", bus.playing_o, 0);
    chk("mid_rst_overflow", bus.overflow_o, 0);
`ifdef DAC_PLAYOUT_STATS_EN
    chk("mid_rst_urun_cnt", bus.underrun_count_o, 0);
    chk("mid_rst_ovf_cnt", bus.overflow_count_o, 0);
`endif
    step();
    chk("post_rst_no_strobe", bus.sample_strobe_o, 0);
    wait_strobe(400, ok);
    chk("post_rst_strobe_cyc", cyc, 375);
    chk("post_rst_data", bus.sample_data_o, 32'h2000);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/dac_playout_buffer.md
Name: dac_playout_buffer

Overview:
- Jitter buffer between the host-link stage and the DAC driver.
- Absorbs bursty 14-bit samples arriving as single-cycle ready pulses from the USB FIFO side.
- Re-emits them at a fixed sample rate derived from clk_i, one strobe per sample period.
- Handles priming, underrun and overflow, so the DAC always receives a steady sample stream.

Parameters:
- DATA_W, 14, sample width.
- DEPTH, 64, FIFO entries; must be a power of 2, ≥ 4.
- PRIME_LEVEL, 32, fill level required before playout starts; 1 ≤ PRIME_LEVEL ≤ DEPTH.
- SAMPLE_DIV, 375, clk_i cycles per output sample (12 MHz / 375 = 32 kHz); ≥ 2.

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  synchronous, active-high reset.
- dac_data_i  in  DATA_W  incoming sample.
- dac_data_rdy_i  in  1  push qualifier; every high cycle is one sample.
- sample_data_o  out  DATA_W  sample presented to the DAC driver.
- sample_strobe_o  out  1  one-cycle pulse; sample_data_o is valid on this cycle.
- playing_o  out  1  high in PLAY state.
- underrun_o  out  1  one-cycle pulse on underrun.
- overflow_o  out  1  one-cycle pulse on a dropped push.
- fill_level_o  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.

Interface: one clock; reset is synchronous and active-high.

Behaviour:
- Reset values:
  - sample_data_o = MIDSCALE (14'h2000).
  - sample_strobe_o, playing_o, underrun_o, overflow_o = 0.
  - fill_level_o = 0; FIFO empty; divider = 0; state = PRIME.
- Reset mid-operation discards all FIFO contents. No strobe in the cycle after reset deasserts.
- Divider:
  - Counts 0..SAMPLE_DIV-1 and wraps, free-running in both states.
  - tick = (divider == SAMPLE_DIV-1). First tick falls at cycle SAMPLE_DIV-1 after reset release.
- Strobe:
  - sample_strobe_o is registered, high the cycle after every tick, in either state.
  - sample_data_o updates on the same edge and holds between strobes.
- Push: a push occurs when dac_data_rdy_i = 1.
  - fill < DEPTH: write dac_data_i.
  - fill == DEPTH with no pop in the same cycle: drop the sample and pulse overflow_o next cycle.
  - fill == DEPTH with a pop in the same cycle: both succeed, fill unchanged, no overflow.
- States:
  - PRIME:
    - No pops; each strobe re-presents the held sample_data_o (last played value, or MIDSCALE after reset).
    - PRIME -> PLAY when fill ≥ PRIME_LEVEL, evaluated on the registered fill. playing_o rises that edge.
  - PLAY:
    - On tick with fill > 0: pop; popped word appears on sample_data_o with the strobe.
    - On tick with fill == 0: underrun. Hold the previous sample_data_o, strobe still fires, underrun_o pulses with it, state -> PRIME.
    - A push in the same cycle as an underrun tick is stored; it is not bypassed.
- fill_level_o = registered occupancy: +1 on accepted push, -1 on pop, unchanged when both occur.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are derived from the count, not from pointer compare.
- Latency: push to earliest playout is at least one tick after the PRIME_LEVEL threshold is reached. There is no combinational path from input to output.

Optional Feature:
- Macro: DAC_PLAYOUT_STATS_EN.
- Defined: adds outputs underrun_count_o[15:0] and overflow_count_o[15:0].
  - Each increments on its event pulse and saturates at 16'hFFFF; cleared only by reset_i.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package dac_playout_pkg:
  - MIDSCALE constant.
  - State encoding localparams: ST_PRIME = 0, ST_PLAY = 1.
  - Counter width constant STAT_W = 16.
- Sub-module sync_fifo (DATA_W, DEPTH):
  - Holds storage, pointers and count; exposes push/pop/full/empty/count.
  - Pop data is registered.
  - Same-cycle push + pop is legal when full.
- Top level owns the divider, state machine, output registers and optional stats.

Test Plan:
- Reset, then 400 idle cycles -> strobe at cycles 375 (±1 register stage) with sample_data_o = 14'h2000; playing_o = 0; fill_level_o = 0.
- Push 32 samples 0x0001..0x0020 back-to-back -> playing_o rises; the next 32 strobes carry 0x0001..0x0020 in order; fill_level_o decrements once per tick.
- After that drain, with no further pushes -> the 33rd strobe repeats 0x0020; underrun_o pulses with it; state PRIME; playing_o = 0.
- Push 70 samples with no pops (PRIME) -> fill_level_o = 64; overflow_o pulses 6 times; playout later yields samples 1..64 only.
- Fill to 64 in PLAY, then hold dac_data_rdy_i high across a tick -> no overflow pulse; fill stays 64.
- With DAC_PLAYOUT_STATS_EN: force 3 underruns and 70 pushes into an empty PRIME buffer -> underrun_count_o = 3, overflow_count_o = 6; reset_i asserted mid-playout -> both read 0, fill_level_o = 0, sample_data_o = 14'h2000.
